// File: rtl/vblank_update_arbiter.sv
// vblank_update_arbiter: grants a shared game-state update slot to N_REQ
// requesters, round-robin, only inside the vertical blanking window.
// Optional build macro VBU_FREEZE_EN adds a 'freeze' input that pauses new grants.
module vblank_update_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned H_ACTIVE     = 800,
    parameter int unsigned V_ACTIVE     = 600,
    parameter int unsigned SLOT_TIMEOUT = 1024
) (
    input  logic              pixel_clk,
    input  logic              rst_n,
    input  logic [10:0]       h_coord,
    input  logic [9:0]        v_coord,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  done,
`ifdef VBU_FREEZE_EN
    input  logic              freeze,
`endif
    output logic [N_REQ-1:0]  gnt,
    output logic              frame_tick,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned TO_W  = $clog2(SLOT_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [N_REQ-1:0]   served_q, served_d;
    logic [TO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic               window_open_q, window_open_d;
    logic [N_REQ-1:0]   gnt_d;
    logic               frame_tick_d, busy_d, overrun_d, timeout_err_d;

    logic               blank_start_c, window_close_c, video_active_c;
    logic               arb_open_c, freeze_act;
    logic [N_REQ-1:0]   eligible_c;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx, cand_idx;

`ifdef VBU_FREEZE_EN
    assign freeze_act = freeze;
`else
    assign freeze_act = 1'b0;
`endif

    // Raster event decode: first blank line start, first visible pixel of frame
    assign blank_start_c  = (v_coord == 10'(V_ACTIVE)) && (h_coord == 11'd0);
    assign window_close_c = (v_coord == 10'd0) && (h_coord == 11'd0);
    assign video_active_c = (v_coord < 10'(V_ACTIVE)) && (h_coord < 11'(H_ACTIVE));
    assign arb_open_c     = window_open_q && !window_close_c;
    assign eligible_c     = req & ~served_q;

    // Round-robin pick: first eligible index searching upward from rr_ptr
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand_idx = IDX_W'((32'(rr_ptr_q) + i) % N_REQ);
            if (!pick_found && eligible_c[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_idx_d     = gnt_idx_q;
        served_d      = served_q;
        tmo_cnt_d     = tmo_cnt_q;
        window_open_d = window_open_q;
        gnt_d         = gnt;
        timeout_err_d = timeout_err;

        if (blank_start_c) begin
            window_open_d = 1'b1;
        end else if (window_close_c) begin
            window_open_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (blank_start_c) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (arb_open_c && !freeze_act && pick_found) begin
                    gnt_d     = N_REQ'(1) << pick_idx;
                    gnt_idx_d = pick_idx;
                    tmo_cnt_d = '0;
                    state_d   = ST_GRANT;
                end else if (arb_open_c && freeze_act) begin
                    state_d = ST_ARB;
                end else if (blank_start_c) begin
                    state_d = ST_ARB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                tmo_cnt_d = tmo_cnt_q + TO_W'(1);
                if (done[gnt_idx_q] || (tmo_cnt_q == TO_W'(SLOT_TIMEOUT - 1))) begin
                    gnt_d               = '0;
                    served_d[gnt_idx_q] = 1'b1;
                    rr_ptr_d            = IDX_W'((32'(gnt_idx_q) + 32'd1) % N_REQ);
                    tmo_cnt_d           = '0;
                    state_d             = ST_ARB;
                    if (!done[gnt_idx_q]) begin
                        timeout_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        // A new window always starts with nobody served
        if (blank_start_c) begin
            served_d = '0;
        end

        frame_tick_d = blank_start_c;
        overrun_d    = (state_q == ST_GRANT) && window_close_c && video_active_c;
        busy_d       = |gnt_d;
    end

    // State and output registers
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            gnt_idx_q     <= '0;
            served_q      <= '0;
            tmo_cnt_q     <= '0;
            window_open_q <= 1'b0;
            gnt           <= '0;
            frame_tick    <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_idx_q     <= gnt_idx_d;
            served_q      <= served_d;
            tmo_cnt_q     <= tmo_cnt_d;
            window_open_q <= window_open_d;
            gnt           <= gnt_d;
            frame_tick    <= frame_tick_d;
            busy          <= busy_d;
            overrun       <= overrun_d;
            timeout_err   <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_vblank_update_arbiter.sv
// Directed self-checking bench for vblank_update_arbiter (SLOT_TIMEOUT=16).
module tb_vblank_update_arbiter;

    logic        pixel_clk = 1'b0;
    logic        rst_n;
    logic [10:0] h_coord;
    logic [9:0]  v_coord;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [3:0]  gnt;
    logic        frame_tick, busy, overrun, timeout_err;
`ifdef VBU_FREEZE_EN
    logic        freeze;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    vblank_update_arbiter #(
        .N_REQ(4), .H_ACTIVE(800), .V_ACTIVE(600), .SLOT_TIMEOUT(16)
    ) dut (
        .pixel_clk  (pixel_clk),
        .rst_n      (rst_n),
        .h_coord    (h_coord),
        .v_coord    (v_coord),
        .req        (req),
        .done       (done),
`ifdef VBU_FREEZE_EN
        .freeze     (freeze),
`endif
        .gnt        (gnt),
        .frame_tick (frame_tick),
        .busy       (busy),
        .overrun    (overrun),
        .timeout_err(timeout_err)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge pixel_clk);
    endtask

    task automatic set_raster(input int v, input int h);
        v_coord = 10'(v);
        h_coord = 11'(h);
    endtask

    // Present v=600,h=0 for one edge; returns with frame_tick visible
    task automatic blank_start();
        set_raster(600, 0);
        tick();
        set_raster(600, 1);
    endtask

    task automatic close_window();
        set_raster(0, 0);
        tick();
        set_raster(100, 100);
    endtask

    task automatic wait_gnt(input string tag, input logic [3:0] exp);
        int k;
        k = 0;
        while (gnt == 4'b0000 && k < 40) begin
            tick();
            k++;
        end
        chk(tag, 32'(gnt), 32'(exp));
    endtask

    // Expect a grant, answer it with done in its third cycle, expect release
    task automatic serve(input string tag, input logic [3:0] exp);
        wait_gnt(tag, exp);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        tick();
        tick();
        done = exp;
        tick();
        done = 4'b0000;
        chk({tag, "_rel"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;
`ifdef VBU_FREEZE_EN
        freeze = 1'b0;
`endif
        set_raster(100, 100);
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a grant
        req = 4'b0100;
        blank_start();
        chk("mid_ft", 32'(frame_tick), 32'd1);
        wait_gnt("mid_gnt", 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_terr", 32'(timeout_err), 32'd0);
        tick();
        rst_n = 1'b1;
        req = 4'b0000;
        set_raster(100, 100);
        tick();
        chk("mid_idle_gnt", 32'(gnt), 32'd0);

        // Window A: req 1011 from rr_ptr 0
        req = 4'b1011;
        blank_start();
        chk("a_ft_hi", 32'(frame_tick), 32'd1);
        tick();
        chk("a_ft_lo", 32'(frame_tick), 32'd0);
        serve("a_g0", 4'b0001);
        serve("a_g1", 4'b0010);
        serve("a_g3", 4'b1000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("a_no_regrant", 32'(gnt), 32'd0);
            chk("a_ft_once", 32'(frame_tick), 32'd0);
        end
        req = 4'b0000;
        close_window();

        // Window B: last served index 1 leaves rr_ptr at 2
        req = 4'b0011;
        blank_start();
        serve("b_g0", 4'b0001);
        serve("b_g1", 4'b0010);
        tick();
        tick();
        chk("b_idle", 32'(gnt), 32'd0);
        close_window();

        // Window C: all request; rotation starts at 2, stray done ignored
        req = 4'b1111;
        blank_start();
        wait_gnt("c_g2", 4'b0100);
        done = 4'b1000;
        tick();
        done = 4'b0000;
        chk("c_stray_done", 32'(gnt), 32'h4);
        tick();
        done = 4'b0100;
        tick();
        done = 4'b0000;
        chk("c_g2_rel", 32'(gnt), 32'd0);
        serve("c_g3", 4'b1000);
        serve("c_g0", 4'b0001);
        serve("c_g1", 4'b0010);
        req = 4'b0000;
        close_window();

        // Window D: slot timeout after exactly 16 cycles
        req = 4'b0011;
        blank_start();
        wait_gnt("d_gnt", 4'b0001);
        for (int i = 0; i < 15; i++) tick();
        chk("d_held15", 32'(gnt), 32'h1);
        chk("d_terr_pre", 32'(timeout_err), 32'd0);
        tick();
        chk("d_drop16", 32'(gnt), 32'd0);
        chk("d_terr_set", 32'(timeout_err), 32'd1);
        serve("d_next", 4'b0010);
        chk("d_terr_sticky", 32'(timeout_err), 32'd1);
        req = 4'b0000;
        close_window();
        chk("d_terr_sticky2", 32'(timeout_err), 32'd1);

        // Window E: grant runs across the close point
        req = 4'b0100;
        set_raster(600, 0);
        tick();
        set_raster(627, 0);
        tick();
        chk("e_gnt", 32'(gnt), 32'h4);
        req = 4'b1111;
        tick();
        tick();
        tick();
        chk("e_ovr_pre", 32'(overrun), 32'd0);
        set_raster(0, 0);
        tick();
        chk("e_ovr_pulse", 32'(overrun), 32'd1);
        chk("e_gnt_kept", 32'(gnt), 32'h4);
        set_raster(0, 1);
        tick();
        chk("e_ovr_end", 32'(overrun), 32'd0);
        chk("e_gnt_kept2", 32'(gnt), 32'h4);
        tick();
        done = 4'b0100;
        tick();
        done = 4'b0000;
        chk("e_rel", 32'(gnt), 32'd0);
        set_raster(100, 100);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("e_no_grant", 32'(gnt), 32'd0);
            chk("e_no_busy", 32'(busy), 32'd0);
        end
        blank_start();
        tick();
        chk("e_next_window", 32'(gnt), 32'h8);

        // Reset clears the sticky timeout flag
        rst_n = 1'b0;
        req = 4'b0000;
        tick();
        chk("f_terr_clr", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        set_raster(100, 100);
        tick();

`ifdef VBU_FREEZE_EN
        // Frozen window: tick still pulses, nothing granted
        req = 4'b1111;
        freeze = 1'b1;
        blank_start();
        chk("z_ft", 32'(frame_tick), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("z_gnt", 32'(gnt), 32'd0);
            chk("z_busy", 32'(busy), 32'd0);
        end
        close_window();
        freeze = 1'b0;
        req = 4'b0000;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
